// File: rtl/hd44780_reader_if.sv
// rtl/hd44780_reader_if.sv - request/response and LCD pin bundle for the HD44780 read path
interface hd44780_reader_if;
   logic       start_strobe;
   logic       rs_sel;
   logic       poll_busy;
   logic [3:0] lcd_data_i;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic       bus_busy;
   logic [7:0] DAT_O;
   logic       end_strobe;
   logic       timeout_o;
   logic [7:0] reads_o;

   modport master (
      output start_strobe, rs_sel, poll_busy, lcd_data_i,
      input  lcd_rs, lcd_rw, lcd_e, bus_busy, DAT_O, end_strobe, timeout_o, reads_o
   );

   modport slave (
      input  start_strobe, rs_sel, poll_busy, lcd_data_i,
      output lcd_rs, lcd_rw, lcd_e, bus_busy, DAT_O, end_strobe, timeout_o, reads_o
   );
endinterface

// File: rtl/hd44780_reader.sv
// rtl/hd44780_reader.sv - HD44780 4-bit read sequencer (status/data read, optional BF polling)
module hd44780_reader #(
   parameter int ADDR_SETUP_CYC = 3,
   parameter int E_HIGH_CYC     = 12,
   parameter int E_LOW_CYC      = 12,
   parameter int CYC_BITS       = 5,
   parameter int POLL_MAX       = 200
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   hd44780_reader_if.slave    bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      EH_HI = 3'd2,
      EL_HI = 3'd3,
      EH_LO = 3'd4,
      EL_LO = 3'd5,
      DONE  = 3'd6
   } state_t;

   localparam logic [CYC_BITS-1:0] L_SETUP = CYC_BITS'(ADDR_SETUP_CYC - 1);
   localparam logic [CYC_BITS-1:0] L_EHIGH = CYC_BITS'(E_HIGH_CYC - 1);
   localparam logic [CYC_BITS-1:0] L_ELOW  = CYC_BITS'(E_LOW_CYC - 1);
   localparam logic [7:0]          L_PMAX  = 8'(POLL_MAX);

   state_t              r_state;
   logic [CYC_BITS-1:0] r_cnt;
   logic                r_rs;
   logic                r_poll;
   logic [7:0]          r_reads;
   logic                r_lcd_rs;
   logic                r_lcd_rw;
   logic                r_lcd_e;
   logic                r_bus_busy;
   logic [7:0]          r_dat;
   logic                r_end;
   logic                r_timeout;
   logic [7:0]          r_reads_o;

   state_t              w_state_next;
   logic [CYC_BITS-1:0] w_cnt_next;
   logic                w_cnt_zero;
   logic                w_accept;
   logic                w_timeout_set;
   logic                w_poll_active;
   logic                w_active;
   logic                w_e_phase;

   assign w_cnt_zero    = (r_cnt == '0);
   assign w_poll_active = r_poll && !r_rs;
   assign w_active      = (r_state == SETUP) || (r_state == EH_HI) || (r_state == EL_HI) ||
                          (r_state == EH_LO) || (r_state == EL_LO);
   assign w_e_phase     = (r_state == EH_HI) || (r_state == EH_LO);

   // Phase counter counts down to zero, then the next state reloads it.
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
      w_accept      = 1'b0;
      w_timeout_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start_strobe) begin
               w_accept     = 1'b1;
               w_state_next = SETUP;
               w_cnt_next   = L_SETUP;
            end
         end
         SETUP: begin
            if (w_cnt_zero) begin
               w_state_next = EH_HI;
               w_cnt_next   = L_EHIGH;
            end
         end
         EH_HI: begin
            if (w_cnt_zero) begin
               w_state_next = EL_HI;
               w_cnt_next   = L_ELOW;
            end
         end
         EL_HI: begin
            if (w_cnt_zero) begin
               w_state_next = EH_LO;
               w_cnt_next   = L_EHIGH;
            end
         end
         EH_LO: begin
            if (w_cnt_zero) begin
               w_state_next = EL_LO;
               w_cnt_next   = L_ELOW;
            end
         end
         EL_LO: begin
            if (w_cnt_zero) begin
               if (w_poll_active && r_dat[7] && (r_reads < L_PMAX)) begin
                  w_state_next = EH_HI;
                  w_cnt_next   = L_EHIGH;
               end else begin
                  w_timeout_set = w_poll_active && r_dat[7];
                  w_state_next  = DONE;
                  w_cnt_next    = '0;
               end
            end
         end
         DONE: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
         end
         default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Pin outputs are registered from the current state, so they trail it by one cycle.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_rs       <= 1'b0;
         r_poll     <= 1'b0;
         r_reads    <= '0;
         r_lcd_rs   <= 1'b0;
         r_lcd_rw   <= 1'b0;
         r_lcd_e    <= 1'b0;
         r_bus_busy <= 1'b0;
         r_dat      <= '0;
         r_end      <= 1'b0;
         r_timeout  <= 1'b0;
         r_reads_o  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_bus_busy <= w_active;
         r_lcd_rw   <= w_active;
         r_lcd_rs   <= w_active ? r_rs : 1'b0;
         r_lcd_e    <= w_e_phase;
         r_end      <= (r_state == DONE);
         if (w_accept) begin
            r_rs      <= bus.rs_sel;
            r_poll    <= bus.poll_busy;
            r_reads   <= '0;
            r_timeout <= 1'b0;
         end
         if ((r_state == EH_HI) && w_cnt_zero) begin
            r_dat[7:4] <= bus.lcd_data_i;
         end
         if ((r_state == EH_LO) && w_cnt_zero) begin
            r_dat[3:0] <= bus.lcd_data_i;
            r_reads    <= r_reads + 8'd1;
         end
         if (w_timeout_set) begin
            r_timeout <= 1'b1;
         end
         if (r_state == DONE) begin
            r_reads_o <= r_reads;
         end
      end
   end

   assign bus.lcd_rs     = r_lcd_rs;
   assign bus.lcd_rw     = r_lcd_rw;
   assign bus.lcd_e      = r_lcd_e;
   assign bus.bus_busy   = r_bus_busy;
   assign bus.DAT_O      = r_dat;
   assign bus.end_strobe = r_end;
   assign bus.timeout_o  = r_timeout;
   assign bus.reads_o    = r_reads_o;

endmodule

// File: doc/hd44780_reader.md
Name: hd44780_reader

Overview:
- Read-side companion to the HD44780 write path: runs 4-bit-mode read cycles (R/W high) on the LCD bus.
- Two read types: a single status read (busy flag + address counter, RS=0) or a single data-RAM read (RS=1).
- Optional mode polls the busy flag until it clears or a read limit is reached, so the LCD sequencer can replace fixed state_timer delays with BF polling.
- Sits beside the writer; the top-level mux hands the lcd_* pins to this block while bus_busy is high.

Parameters:
ADDR_SETUP_CYC, 3, cycles RS/RW are stable before the first E rise (tAS; 62 ns at 48 MHz)
E_HIGH_CYC, 12, cycles E is held high per nibble (PWEH/tDDR; 250 ns at 48 MHz)
E_LOW_CYC, 12, cycles E is held low after each nibble (completes tcycE, covers tH/tAH)
CYC_BITS, 5, phase counter width; must hold max(ADDR_SETUP_CYC, E_HIGH_CYC, E_LOW_CYC)
POLL_MAX, 200, maximum status reads per poll transaction (1..255)

Ports:
CLK_I  in  1  system clock (48 MHz)
RST_I  in  1  synchronous reset, active-high
start_strobe  in  1  one-cycle request; sampled only in IDLE
rs_sel  in  1  captured at start: 0 = status read, 1 = data read
poll_busy  in  1  captured at start; honoured only when rs_sel=0
lcd_data_i  in  4  LCD D7..D4 input
lcd_rs  out  1  register select
lcd_rw  out  1  1 during a read transaction
lcd_e  out  1  enable strobe
bus_busy  out  1  high while this block owns the LCD pins; top must tristate its data drivers
DAT_O  out  8  last byte read; {high nibble, low nibble}
end_strobe  out  1  one-cycle completion pulse
timeout_o  out  1  poll ended with BF still 1; valid from end_strobe until the next start
reads_o  out  8  number of reads in the last transaction

Behaviour:
- Reset (synchronous; applies in any state, including mid-transaction):
  - lcd_e=0, lcd_rw=0, lcd_rs=0, bus_busy=0, DAT_O=0, end_strobe=0, timeout_o=0, reads_o=0.
  - FSM returns to IDLE; no end_strobe is generated for an aborted transaction.
- States: IDLE, SETUP, EH_HI, EL_HI, EH_LO, EL_LO, DONE. A single CYC_BITS down-counter is loaded on every state entry.
- IDLE:
  - Outputs lcd_e=0, lcd_rw=0, bus_busy=0.
  - On start_strobe: capture rs_sel and poll_busy, clear timeout_o and the read counter, go to SETUP.
- SETUP: lcd_rs=captured rs_sel, lcd_rw=1, lcd_e=0, bus_busy=1 for ADDR_SETUP_CYC cycles. Then go to EH_HI.
- EH_HI: lcd_e=1 for E_HIGH_CYC cycles. On the final cycle, register lcd_data_i into DAT_O[7:4]. Then go to EL_HI.
- EL_HI: lcd_e=0 for E_LOW_CYC cycles. Then go to EH_LO.
- EH_LO: lcd_e=1 for E_HIGH_CYC cycles. On the final cycle, register lcd_data_i into DAT_O[3:0] and increment the read counter. Then go to EL_LO.
- EL_LO: lcd_e=0 for E_LOW_CYC cycles. Then:
  - if poll is active (captured poll_busy=1 and rs_sel=0) and DAT_O[7]=1 and reads < POLL_MAX: go to EH_HI; RS/RW stay asserted and SETUP is not repeated.
  - else if poll is active and DAT_O[7]=1: set timeout_o, go to DONE.
  - else: go to DONE.
- DONE (one cycle): end_strobe=1, bus_busy=0, lcd_rw=0, reads_o=read counter. Next state IDLE.
- DAT_O, reads_o and timeout_o hold their values until the next accepted start.
- Latency: a single read with defaults puts end_strobe 1+3+2*(12+12) = 52 cycles after the edge that sampled start_strobe. Each extra poll read adds 2*(E_HIGH_CYC+E_LOW_CYC) = 48 cycles.
- lcd_data_i is sampled only in the last E-high cycle (at least E_HIGH_CYC-1 cycles after the E rise, which meets tDDR). No other sampling occurs.
- start_strobe outside IDLE (including the DONE cycle) is ignored; no queuing.
- A non-poll read with rs_sel=0 returns BF in DAT_O[7] and AC in DAT_O[6:0]; timeout_o stays 0.
- poll_busy with rs_sel=1 is ignored: exactly one data read is performed.
- Outputs are registered and glitch-free; lcd_e never toggles while bus_busy=0.

Test Plan:
- Status read, rs_sel=0, poll_busy=0, LCD model returns 0x3 then 0x5 → end_strobe exactly 52 cycles after start; DAT_O=0x35, reads_o=1, timeout_o=0, lcd_rs=0; exactly two 12-cycle E pulses with lcd_rw=1 throughout.
- Data read, rs_sel=1, model returns 0xA,0xC → DAT_O=0xAC, lcd_rs=1 from SETUP through EL_LO, lcd_rw back to 0 in the DONE cycle, bus_busy falls with end_strobe.
- Poll, rs_sel=0, poll_busy=1, model returns BF=1 for 3 reads then 0x0,0x4 → reads_o=4, DAT_O=0x04, timeout_o=0; end_strobe at 52+3*48 = 196 cycles; only one SETUP phase.
- Timeout, POLL_MAX=4, BF held at 1 (model returns 0x8,0x0) → reads_o=4, timeout_o=1, DAT_O=0x80, end_strobe at 196 cycles.
- RST_I asserted for 1 cycle during the second E-high phase → next edge has lcd_e=0, lcd_rw=0, bus_busy=0, DAT_O=0; no end_strobe; a new start afterwards completes normally in 52 cycles.
- start_strobe pulsed at cycles 10 and 52 of an ongoing transaction → both ignored; exactly one end_strobe; bus_busy stays low afterwards.
